bridge_arbiter: RTL and testbench
=================================

BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, requester/bridge address width.
REQ-002 Parameter DATA_W, default 64, requester/bridge data width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pN_in_valid  in  1  request strobe, port N in {0,1}, one cycle.
REQ-007 pN_r_wb  in  1  1=read, 0=write, sampled with pN_in_valid.
REQ-008 pN_addr  in  ADDR_W  entry index, sampled with pN_in_valid.
REQ-009 pN_data_w  in  DATA_W  write data, sampled with pN_in_valid.
REQ-010 pN_busy  out  1  port buffer full or transaction outstanding.
REQ-011 pN_out_valid  out  1  one-cycle completion pulse.
REQ-012 pN_data_r  out  DATA_W  read data, valid with pN_out_valid.
REQ-013 br_in_valid  out  1  one-cycle request pulse to bridge.
REQ-014 br_r_wb / br_addr / br_data_w  out  1/ADDR_W/DATA_W  bridge request fields.
REQ-015 br_out_valid  in  1  bridge completion pulse.
REQ-016 br_data_r  in  DATA_W  bridge read data, valid with br_out_valid.

Function
REQ-017 Each port SHALL hold a 1-entry buffer; pN_in_valid with pN_busy=0 captures r_wb/addr/data_w, buffer full next cycle.
REQ-018 pN_in_valid while pN_busy=1 SHALL be dropped with no state change.
REQ-019 pN_busy SHALL be 1 from the cycle after capture until the cycle after pN_out_valid.
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: any buffer full -> latch grant and fields into registers, go ISSUE; else stay.
REQ-022 ISSUE: br_in_valid=1 for exactly one cycle with latched fields -> WAIT.
REQ-023 WAIT: br_out_valid=1 -> capture br_data_r (reads) or 0 (writes) -> RESP; else stay, no timeout.
REQ-024 RESP: granted pN_out_valid=1, pN_data_r=captured data for one cycle; clear that buffer; update last-grant -> IDLE.
REQ-025 Latency: pN_in_valid in idle cycle t -> br_in_valid in t+2; br_out_valid in cycle c -> pN_out_valid in c+1.
REQ-026 Default arbitration round-robin: both buffers full in IDLE -> grant port != last-grant; single full buffer wins.
REQ-027 br_out_valid outside WAIT SHALL be ignored.
REQ-028 All br_* and pN_data_r outputs SHALL be 0 when their valid is 0.
REQ-029 Non-granted port buffer SHALL be held unchanged throughout a transaction.

Reset
REQ-030 rst=1 SHALL force IDLE, empty buffers, last-grant=1 (port 0 first), all outputs 0.
REQ-031 Reset mid-transaction SHALL discard it; a later stray br_out_valid is ignored per REQ-027.

Configuration
REQ-032 Macro BRIDGE_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win when both buffers full; last-grant unused.
REQ-033 Macro undefined: round-robin per REQ-026.

Structure
REQ-034 Shared package bridge_arb_pkg SHALL hold the FSM state typedef, ADDR_W/DATA_W defaults, and the request struct (r_wb, addr, data_w).
REQ-035 One sub-module arb_req_buf (per-port 1-entry buffer with busy) SHALL be instantiated twice.

Verification
REQ-036 p0 write addr=0x05 data=0xDEAD_BEEF, bridge acks 3 cycles after br_in_valid -> br_addr=0x05, br_r_wb=0, p0_out_valid 1 cycle after ack, p0_data_r=0.
REQ-037 p1 read addr=0xFF, bridge returns 0x0123_4567_89AB_CDEF -> p1_out_valid with that data, p0 untouched.
REQ-038 p0 and p1 strobe same cycle, after reset -> p0 served first, then p1 (fixed-prio build: p0 first; repeated dual strobe -> p0 always first).
REQ-039 p0 strobe twice while busy -> second dropped, exactly one br_in_valid for p0.
REQ-040 rst asserted in WAIT, then br_out_valid -> no pN_out_valid, all outputs 0, next request served normally.
REQ-041 br_out_valid pulsed in IDLE -> no output change.

Source files
------------

// File: rtl/bridge_arb_pkg.sv
// bridge_arb_pkg
// Shared definitions for the two-port bridge arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default request address/data widths
//   NPORTS                  : number of requester ports (fixed at 2)
//   state_t                 : arbiter FSM state encoding
//   req_t                   : one request (r_wb, addr, data_w) at default widths
//   rr_pick                 : round-robin grant selection helper
package bridge_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 64;
  localparam int NPORTS     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  r_wb;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data_w;
  } req_t;

  // Returns the port index to grant. With both buffers full the port that
  // did not win last time is chosen; otherwise the single full one wins.
  function automatic logic rr_pick(input logic full0, input logic full1,
                                   input logic last_grant);
    if (full0 && full1) begin
      return ~last_grant;
    end else if (full0) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/arb_req_buf.sv
// arb_req_buf
// One-entry request buffer for a single requester port.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid            : request strobe (dropped while busy)
//   r_wb, addr, data_w  : request fields sampled with in_valid
//   clr                 : empties the buffer (transaction completed)
//   busy                : buffer holds a request (full until cleared)
//   buf_r_wb, buf_addr, buf_data_w : stored request fields
module arb_req_buf
  import bridge_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              r_wb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_w,
  input  logic              clr,
  output logic              busy,
  output logic              buf_r_wb,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data_w
);

  logic              full_reg;
  logic              r_wb_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_w_reg;

  // The buffer stays full for the whole transaction, so busy also covers
  // the "transaction outstanding" period; clr only arrives while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg   <= 1'b0;
      r_wb_reg   <= 1'b0;
      addr_reg   <= '0;
      data_w_reg <= '0;
    end else if (clr) begin
      full_reg <= 1'b0;
    end else if (in_valid && !full_reg) begin
      full_reg   <= 1'b1;
      r_wb_reg   <= r_wb;
      addr_reg   <= addr;
      data_w_reg <= data_w;
    end
  end

  assign busy       = full_reg;
  assign buf_r_wb   = r_wb_reg;
  assign buf_addr   = addr_reg;
  assign buf_data_w = data_w_reg;

endmodule

// File: rtl/bridge_arbiter.sv
// bridge_arbiter
// Arbitrates two single-outstanding requester ports onto one bridge.
//   clk, rst                 : clock, synchronous active-high reset
//   pN_in_valid/r_wb/addr/data_w : port N request (N = 0, 1)
//   pN_busy                  : port N buffer full / transaction outstanding
//   pN_out_valid, pN_data_r  : port N completion pulse and read data
//   br_in_valid/r_wb/addr/data_w : one-cycle request to the bridge
//   br_out_valid, br_data_r  : bridge completion pulse and read data
// Build option: define BRIDGE_ARB_FIXED_PRIO_EN to make port 0 always win
// when both buffers are full; otherwise arbitration is round-robin.
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_in_valid,
  input  logic              p0_r_wb,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data_w,
  output logic              p0_busy,
  output logic              p0_out_valid,
  output logic [DATA_W-1:0] p0_data_r,
  input  logic              p1_in_valid,
  input  logic              p1_r_wb,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data_w,
  output logic              p1_busy,
  output logic              p1_out_valid,
  output logic [DATA_W-1:0] p1_data_r,
  output logic              br_in_valid,
  output logic              br_r_wb,
  output logic [ADDR_W-1:0] br_addr,
  output logic [DATA_W-1:0] br_data_w,
  input  logic              br_out_valid,
  input  logic [DATA_W-1:0] br_data_r
);

  // Per-port views so the buffers can be generated uniformly.
  logic [NPORTS-1:0] in_valid_vec;
  logic [NPORTS-1:0] r_wb_vec;
  logic [NPORTS-1:0] busy_vec;
  logic [NPORTS-1:0] clr_vec;
  logic [NPORTS-1:0] buf_r_wb_vec;
  logic [ADDR_W-1:0] addr_arr     [NPORTS];
  logic [DATA_W-1:0] data_w_arr   [NPORTS];
  logic [ADDR_W-1:0] buf_addr_arr [NPORTS];
  logic [DATA_W-1:0] buf_data_arr [NPORTS];

  state_t            state_reg;
  logic              grant_reg;
  logic              grant_next;
  logic              req_r_wb_reg;
  logic              br_in_valid_reg;
  logic              br_r_wb_reg;
  logic [ADDR_W-1:0] br_addr_reg;
  logic [DATA_W-1:0] br_data_w_reg;
  logic [NPORTS-1:0] out_valid_reg;
  logic [DATA_W-1:0] data_r_reg [NPORTS];
`ifndef BRIDGE_ARB_FIXED_PRIO_EN
  logic              last_grant_reg;
`endif

  assign in_valid_vec  = {p1_in_valid, p0_in_valid};
  assign r_wb_vec      = {p1_r_wb, p0_r_wb};
  assign addr_arr[0]   = p0_addr;
  assign addr_arr[1]   = p1_addr;
  assign data_w_arr[0] = p0_data_w;
  assign data_w_arr[1] = p1_data_w;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_buf
      arb_req_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
      ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_vec[gi]),
        .r_wb       (r_wb_vec[gi]),
        .addr       (addr_arr[gi]),
        .data_w     (data_w_arr[gi]),
        .clr        (clr_vec[gi]),
        .busy       (busy_vec[gi]),
        .buf_r_wb   (buf_r_wb_vec[gi]),
        .buf_addr   (buf_addr_arr[gi]),
        .buf_data_w (buf_data_arr[gi])
      );
      // The granted buffer empties at the end of the completion cycle, so
      // busy drops the cycle after pN_out_valid.
      assign clr_vec[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
    grant_next = busy_vec[0] ? 1'b0 : 1'b1;
`else
    grant_next = rr_pick(busy_vec[0], busy_vec[1], last_grant_reg);
`endif
  end

  // All bridge/port outputs are registered and forced to zero whenever
  // their valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      grant_reg       <= 1'b0;
      req_r_wb_reg    <= 1'b0;
      br_in_valid_reg <= 1'b0;
      br_r_wb_reg     <= 1'b0;
      br_addr_reg     <= '0;
      br_data_w_reg   <= '0;
      out_valid_reg   <= '0;
      for (int i = 0; i < NPORTS; i++) data_r_reg[i] <= '0;
`ifndef BRIDGE_ARB_FIXED_PRIO_EN
      last_grant_reg  <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|busy_vec) begin
            grant_reg       <= grant_next;
            req_r_wb_reg    <= buf_r_wb_vec[grant_next];
            br_in_valid_reg <= 1'b1;
            br_r_wb_reg     <= buf_r_wb_vec[grant_next];
            br_addr_reg     <= buf_addr_arr[grant_next];
            br_data_w_reg   <= buf_data_arr[grant_next];
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          br_in_valid_reg <= 1'b0;
          br_r_wb_reg     <= 1'b0;
          br_addr_reg     <= '0;
          br_data_w_reg   <= '0;
          state_reg       <= WAIT;
        end
        WAIT: begin
          if (br_out_valid) begin
            out_valid_reg[grant_reg] <= 1'b1;
            data_r_reg[grant_reg]    <= req_r_wb_reg ? br_data_r : '0;
            state_reg                <= RESP;
          end
        end
        RESP: begin
          out_valid_reg         <= '0;
          data_r_reg[grant_reg] <= '0;
`ifndef BRIDGE_ARB_FIXED_PRIO_EN
          last_grant_reg        <= grant_reg;
`endif
          state_reg             <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign p0_busy      = busy_vec[0];
  assign p1_busy      = busy_vec[1];
  assign p0_out_valid = out_valid_reg[0];
  assign p1_out_valid = out_valid_reg[1];
  assign p0_data_r    = data_r_reg[0];
  assign p1_data_r    = data_r_reg[1];
  assign br_in_valid  = br_in_valid_reg;
  assign br_r_wb      = br_r_wb_reg;
  assign br_addr      = br_addr_reg;
  assign br_data_w    = br_data_w_reg;

endmodule

// File: tb/tb_bridge_arbiter.sv
module tb_bridge_arbiter;
  import bridge_arb_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic          clk;
  logic          rst;
  logic          p0_in_valid, p0_r_wb, p0_busy, p0_out_valid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_data_w, p0_data_r;
  logic          p1_in_valid, p1_r_wb, p1_busy, p1_out_valid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_data_w, p1_data_r;
  logic          br_in_valid, br_r_wb, br_out_valid;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_data_w, br_data_r;

  int checks = 0;
  int errors = 0;
  int br_cnt = 0;
  int ov0_cnt = 0;

  bridge_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_in_valid  (p0_in_valid),
    .p0_r_wb      (p0_r_wb),
    .p0_addr      (p0_addr),
    .p0_data_w    (p0_data_w),
    .p0_busy      (p0_busy),
    .p0_out_valid (p0_out_valid),
    .p0_data_r    (p0_data_r),
    .p1_in_valid  (p1_in_valid),
    .p1_r_wb      (p1_r_wb),
    .p1_addr      (p1_addr),
    .p1_data_w    (p1_data_w),
    .p1_busy      (p1_busy),
    .p1_out_valid (p1_out_valid),
    .p1_data_r    (p1_data_r),
    .br_in_valid  (br_in_valid),
    .br_r_wb      (br_r_wb),
    .br_addr      (br_addr),
    .br_data_w    (br_data_w),
    .br_out_valid (br_out_valid),
    .br_data_r    (br_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (br_in_valid)  br_cnt  <= br_cnt + 1;
    if (p0_out_valid) ov0_cnt <= ov0_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both ports for one cycle, then return all request inputs to 0.
  task automatic strobe(input logic v0, input req_t r0, input logic v1, input req_t r1);
    p0_in_valid = v0; p0_r_wb = r0.r_wb; p0_addr = r0.addr; p0_data_w = r0.data_w;
    p1_in_valid = v1; p1_r_wb = r1.r_wb; p1_addr = r1.addr; p1_data_w = r1.data_w;
    tick();
    p0_in_valid = 1'b0; p0_r_wb = 1'b0; p0_addr = '0; p0_data_w = '0;
    p1_in_valid = 1'b0; p1_r_wb = 1'b0; p1_addr = '0; p1_data_w = '0;
  endtask

  task automatic wait_issue(input string tag, input int max);
    for (int i = 0; i < max && !br_in_valid; i++) tick();
    check({tag, "_issue"}, br_in_valid, 1'b1);
  endtask

  // Called in the br_in_valid cycle: acknowledge in the next (WAIT) cycle and
  // return positioned in the completion cycle.
  task automatic ack(input logic [63:0] d);
    tick();
    br_out_valid = 1'b1;
    br_data_r    = d;
    tick();
    br_out_valid = 1'b0;
    br_data_r    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  req_t z, ra, rb;
  int   base;
  logic first_port;
  logic [AW-1:0] first_addr, second_addr;

  initial begin
    z = '0;
    rst = 1'b1;
    p0_in_valid = 0; p0_r_wb = 0; p0_addr = '0; p0_data_w = '0;
    p1_in_valid = 0; p1_r_wb = 0; p1_addr = '0; p1_data_w = '0;
    br_out_valid = 0; br_data_r = '0;
    repeat (3) tick();
    check("rst_p0_busy", p0_busy, 1'b0);
    check("rst_p1_busy", p1_busy, 1'b0);
    check("rst_br_in_valid", br_in_valid, 1'b0);
    check("rst_br_addr", br_addr, 0);
    check("rst_p0_out_valid", p0_out_valid, 1'b0);
    check("rst_p1_data_r", p1_data_r, 0);
    rst = 1'b0;
    tick();

    // p0 write, bridge acks 3 cycles after br_in_valid
    ra = '{r_wb: 1'b0, addr: 8'h05, data_w: 64'hDEAD_BEEF};
    strobe(1'b1, ra, 1'b0, z);
    check("w_busy_t1", p0_busy, 1'b1);
    check("w_br_in_valid_t1", br_in_valid, 1'b0);
    tick();
    check("w_br_in_valid_t2", br_in_valid, 1'b1);
    check("w_br_addr", br_addr, 8'h05);
    check("w_br_r_wb", br_r_wb, 1'b0);
    check("w_br_data_w", br_data_w, 64'hDEAD_BEEF);
    repeat (3) tick();
    check("w_br_in_valid_off", br_in_valid, 1'b0);
    check("w_br_data_w_off", br_data_w, 0);
    br_out_valid = 1'b1;
    br_data_r    = 64'h1111_2222_3333_4444;
    check("w_p0_out_valid_early", p0_out_valid, 1'b0);
    tick();
    br_out_valid = 1'b0;
    br_data_r    = '0;
    check("w_p0_out_valid", p0_out_valid, 1'b1);
    check("w_p0_data_r", p0_data_r, 0);
    check("w_p1_out_valid", p1_out_valid, 1'b0);
    check("w_p0_busy_resp", p0_busy, 1'b1);
    tick();
    check("w_p0_out_valid_off", p0_out_valid, 1'b0);
    check("w_p0_busy_off", p0_busy, 1'b0);

    // p1 read
    rb = '{r_wb: 1'b1, addr: 8'hFF, data_w: 64'h0};
    strobe(1'b0, z, 1'b1, rb);
    wait_issue("r1", 5);
    check("r1_br_addr", br_addr, 8'hFF);
    check("r1_br_r_wb", br_r_wb, 1'b1);
    ack(64'h0123_4567_89AB_CDEF);
    check("r1_p1_out_valid", p1_out_valid, 1'b1);
    check("r1_p1_data_r", p1_data_r, 64'h0123_4567_89AB_CDEF);
    check("r1_p0_out_valid", p0_out_valid, 1'b0);
    check("r1_p0_busy", p0_busy, 1'b0);
    tick();

    // dual strobe after reset: p0 first, then p1
    do_reset();
    ra = '{r_wb: 1'b1, addr: 8'h10, data_w: 64'h0};
    rb = '{r_wb: 1'b1, addr: 8'h20, data_w: 64'h0};
    strobe(1'b1, ra, 1'b1, rb);
    wait_issue("d1", 5);
    check("d1_br_addr", br_addr, 8'h10);
    ack(64'hA0);
    check("d1_p0_out_valid", p0_out_valid, 1'b1);
    check("d1_p0_data_r", p0_data_r, 64'hA0);
    check("d1_p1_out_valid", p1_out_valid, 1'b0);
    check("d1_p1_busy_held", p1_busy, 1'b1);
    wait_issue("d2", 6);
    check("d2_br_addr", br_addr, 8'h20);
    ack(64'hB0);
    check("d2_p1_out_valid", p1_out_valid, 1'b1);
    check("d2_p1_data_r", p1_data_r, 64'hB0);
    tick();

    // p0 served alone, then dual strobe: round-robin picks p1, fixed picks p0
    ra = '{r_wb: 1'b0, addr: 8'h30, data_w: 64'h3};
    strobe(1'b1, ra, 1'b0, z);
    wait_issue("f0", 5);
    ack(64'h0);
    check("f0_p0_out_valid", p0_out_valid, 1'b1);
    tick();
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
    first_port = 1'b0;
`else
    first_port = 1'b1;
`endif
    first_addr  = first_port ? 8'h42 : 8'h41;
    second_addr = first_port ? 8'h41 : 8'h42;
    ra = '{r_wb: 1'b1, addr: 8'h41, data_w: 64'h0};
    rb = '{r_wb: 1'b1, addr: 8'h42, data_w: 64'h0};
    strobe(1'b1, ra, 1'b1, rb);
    wait_issue("f1", 5);
    check("f1_br_addr", br_addr, first_addr);
    ack(64'hC1);
    check("f1_out_valid", first_port ? p1_out_valid : p0_out_valid, 1'b1);
    check("f1_other_out_valid", first_port ? p0_out_valid : p1_out_valid, 1'b0);
    wait_issue("f2", 6);
    check("f2_br_addr", br_addr, second_addr);
    ack(64'hC2);
    check("f2_out_valid", first_port ? p0_out_valid : p1_out_valid, 1'b1);
    tick();

    // second strobe while busy is dropped
    base = br_cnt;
    ra = '{r_wb: 1'b0, addr: 8'h50, data_w: 64'h55};
    rb = '{r_wb: 1'b0, addr: 8'h66, data_w: 64'h66};
    strobe(1'b1, ra, 1'b0, z);
    strobe(1'b1, rb, 1'b0, z);
    wait_issue("b1", 5);
    check("b1_br_addr", br_addr, 8'h50);
    check("b1_br_data_w", br_data_w, 64'h55);
    ack(64'h0);
    check("b1_p0_out_valid", p0_out_valid, 1'b1);
    repeat (6) tick();
    check("b1_issue_count", br_cnt - base, 1);
    check("b1_p0_busy", p0_busy, 1'b0);

    // reset while waiting on the bridge, then a stray ack
    ra = '{r_wb: 1'b1, addr: 8'h60, data_w: 64'h0};
    strobe(1'b1, ra, 1'b0, z);
    wait_issue("x1", 5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("x1_br_in_valid", br_in_valid, 1'b0);
    check("x1_br_addr", br_addr, 0);
    check("x1_p0_busy", p0_busy, 1'b0);
    check("x1_p0_data_r", p0_data_r, 0);
    base = ov0_cnt;
    br_out_valid = 1'b1;
    br_data_r    = 64'hBAD;
    tick();
    br_out_valid = 1'b0;
    br_data_r    = '0;
    tick();
    check("x1_no_p0_out", ov0_cnt - base, 0);
    check("x1_p0_data_r_after", p0_data_r, 0);
    rb = '{r_wb: 1'b1, addr: 8'h70, data_w: 64'h0};
    strobe(1'b0, z, 1'b1, rb);
    wait_issue("x2", 5);
    check("x2_br_addr", br_addr, 8'h70);
    ack(64'h77);
    check("x2_p1_out_valid", p1_out_valid, 1'b1);
    check("x2_p1_data_r", p1_data_r, 64'h77);
    tick();

    // br_out_valid in IDLE is ignored
    tick();
    base = br_cnt;
    br_out_valid = 1'b1;
    br_data_r    = 64'hCAFE;
    tick();
    br_out_valid = 1'b0;
    br_data_r    = '0;
    tick();
    check("i1_p0_out_valid", p0_out_valid, 1'b0);
    check("i1_p1_out_valid", p1_out_valid, 1'b0);
    check("i1_p1_data_r", p1_data_r, 0);
    check("i1_br_in_valid", br_in_valid, 1'b0);
    check("i1_issue_count", br_cnt - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
